maxnet_iter_ctrl: RTL
=====================

# maxnet_iter_ctrl

Iteration controller wrapped around the combinational 4-lane processing unit. Accepts four FP32 activations over a valid/ready handshake and drives them into the processing unit. Each cycle it takes back the unit's four outputs, applies ReLU and re-registers them. It stops when at most one lane is non-zero or an iteration cap is hit, then presents the winning lane on a valid/ready result port.

## Interface
- MAX_ITER, 64: maximum processing-unit passes before forced stop.
- ITER_W, 7: width of iteration counter; must satisfy 2^ITER_W > MAX_ITER.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- in_valid  in  1  input vector valid.
- in_ready  out  1  controller can accept a vector (high only in IDLE).
- in_x1..in_x4  in  32 each  FP32 input activations.
- pu_x1..pu_x4  out  32 each  current registered activations, wired to the processing unit's x1..x4.
- pu_1_in..pu_4_in  in  32 each  processing unit's pu_1_out..pu_4_out, same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_winner  out  2  winning lane index (0..3).
- out_value  out  32  FP32 value of winning lane.
- out_none  out  1  all lanes zero at stop.
- out_timeout  out  1  stopped because the iteration count reached MAX_ITER.
- out_iters  out  ITER_W  passes performed.

## Operation
- ReLU rule, applied lane-wise on load and on every feedback:
  - sign bit 1 -> +0 (0x00000000).
  - exponent field 0 (zero or denormal) -> +0.
  - exponent 0xFF: NaN/Inf are unsupported and flushed to +0.
  - otherwise the value passes unchanged.
- Non-zero means ReLU result != 0x00000000.
- Argmax: lanes are non-negative after ReLU, so the comparison is an unsigned 32-bit compare. Ties go to the lowest index.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: x_r <= relu(in_x*), iter <= 0, go to RUN.
  - RUN, evaluated on x_r every cycle:
    - nz_count <= 1 -> go to DONE, timeout=0.
    - else iter == MAX_ITER -> go to DONE, timeout=1.
    - else x_r <= relu(pu_*_in), iter <= iter+1, stay in RUN.
  - DONE:
    - out_valid=1.
    - Result fields are latched on entry and held stable.
    - out_valid && out_ready -> go to IDLE.
- Result on entry to DONE:
  - out_winner = argmax(x_r) and out_value = x_r[out_winner].
  - out_none = (nz_count == 0). When out_none=1: winner=0, value=0.
  - out_iters = iter.
- pu_x* always equal x_r. They are held constant outside RUN.
- in_valid is ignored outside IDLE. No input queueing.

## Timing
- Reset (rst=0, async): state=IDLE, x_r=0, iter=0, all out_* = 0, pu_x* = 0. in_ready=0 while rst=0, and 1 from the first clock edge after release.
- Reset mid-RUN or mid-DONE aborts immediately. No result is produced.
- Input accepted at edge 0. A vector that already has <=1 non-zero gives out_valid high after edge 1, i.e. 2 cycles from acceptance, with out_iters=0.
- N feedback passes: out_valid after edge N+1. Worst case MAX_ITER+1 edges after acceptance.
- One processing-unit pass per cycle. The combinational path pu_x* -> processing unit -> pu_*_in -> relu -> x_r must close in one cycle.
- Result handshake completes in the cycle out_valid && out_ready. in_ready rises the following cycle. There is no same-cycle result-to-input turnaround.

## Structure
- Shared package holds:
  - FP32_W = 32 and the FP32_ZERO constant.
  - the sign/exponent field positions.
  - state enum {IDLE, RUN, DONE}.
- Sub-module relu_fp32: 32-bit in, 32-bit out, purely combinational. Instantiated 4x on the load path and 4x on the feedback path, or 4x muxed between the two.
- Argmax and nz_count are inline combinational logic in the controller.
- The processing unit is instantiated beside the controller at the parent level, not inside it.

## Test plan
- Single non-zero: in = {0x3F800000, 0, 0, 0} -> out_valid at cycle 2, winner=0, value=0x3F800000, iters=0, none=0, timeout=0.
- All negative: in = {0xBF800000, 0xBF000000, 0x80000000, 0xC0000000} -> none=1, winner=0, value=0, iters=0.
- Convergence:
  - Stimulus: in = {0x3F800000, 0x3F000000, 0x3F000000, 0x3F000000}. The bench PU model returns {0x3F000000, 0xBE4CCCCD, 0xBE4CCCCD, 0xBE4CCCCD} on the first pass.
  - Required: iters=1, winner=0, value=0x3F000000, timeout=0, out_valid at cycle 3.
- Timeout: MAX_ITER=4, PU model echoes its inputs, in = {0x3F000000, 0x3F800000, 0x3F800000, 0x3E4CCCCD} -> timeout=1, iters=4, winner=1 (tie with lane 2 goes to lower index), value=0x3F800000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid -> all out_* stable, in_ready=0, no new load. out_ready=1 -> IDLE the next cycle.
- Reset mid-RUN: drop rst during pass 2 of the timeout case -> out_valid=0, pu_x*=0 and in_ready=0 asynchronously. After release, a fresh single-non-zero vector completes normally.

Source files
------------

// File: rtl/maxnet_iter_ctrl_pkg.sv
// rtl/maxnet_iter_ctrl_pkg.sv - shared FP32 field layout and controller state encoding
package maxnet_iter_ctrl_pkg;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP32_ZERO = '0;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/maxnet_iter_ctrl_relu_fp32.sv
// rtl/maxnet_iter_ctrl_relu_fp32.sv - FP32 ReLU that also flushes denormals, NaN and Inf to +0
module relu_fp32
  import maxnet_iter_ctrl_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  output logic [FP32_W-1:0] y
);

  logic [EXP_W-1:0] exp_f;

  assign exp_f = a[EXP_MSB:EXP_LSB];

  always_comb begin
    if (a[SIGN_BIT] || (exp_f == '0) || (exp_f == '1)) begin
      y = FP32_ZERO;
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/maxnet_iter_ctrl.sv
// rtl/maxnet_iter_ctrl.sv - iterates an external 4-lane processing unit until one lane survives
module maxnet_iter_ctrl
  import maxnet_iter_ctrl_pkg::*;
#(
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_x1,
  input  logic [31:0]       in_x2,
  input  logic [31:0]       in_x3,
  input  logic [31:0]       in_x4,
  output logic [31:0]       pu_x1,
  output logic [31:0]       pu_x2,
  output logic [31:0]       pu_x3,
  output logic [31:0]       pu_x4,
  input  logic [31:0]       pu_1_in,
  input  logic [31:0]       pu_2_in,
  input  logic [31:0]       pu_3_in,
  input  logic [31:0]       pu_4_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_winner,
  output logic [31:0]       out_value,
  output logic              out_none,
  output logic              out_timeout,
  output logic [ITER_W-1:0] out_iters
);

  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t            state, state_nxt;
  logic [FP32_W-1:0] x_r      [LANES];
  logic [FP32_W-1:0] load_raw [LANES];
  logic [FP32_W-1:0] fb_raw   [LANES];
  logic [FP32_W-1:0] relu_in  [LANES];
  logic [FP32_W-1:0] relu_out [LANES];
  logic [ITER_W-1:0] iter;
  logic              rdy_en;

  logic              load_x;
  logic              iter_clr;
  logic              iter_inc;
  logic              latch_res;
  logic              timeout_nxt;

  logic [2:0]        nz_count;
  logic [1:0]        best_idx;
  logic [FP32_W-1:0] best_val;

  assign load_raw[0] = in_x1;
  assign load_raw[1] = in_x2;
  assign load_raw[2] = in_x3;
  assign load_raw[3] = in_x4;
  assign fb_raw[0]   = pu_1_in;
  assign fb_raw[1]   = pu_2_in;
  assign fb_raw[2]   = pu_3_in;
  assign fb_raw[3]   = pu_4_in;

  // One ReLU bank shared by load and feedback: only IDLE loads from the input port.
  for (genvar g = 0; g < LANES; g++) begin : g_relu
    assign relu_in[g] = (state == IDLE) ? load_raw[g] : fb_raw[g];
    relu_fp32 u_relu (
      .a (relu_in[g]),
      .y (relu_out[g])
    );
  end

  assign pu_x1 = x_r[0];
  assign pu_x2 = x_r[1];
  assign pu_x3 = x_r[2];
  assign pu_x4 = x_r[3];

  // Lanes are non-negative after ReLU, so an unsigned compare orders them; strict > keeps ties low.
  always_comb begin
    nz_count = '0;
    best_idx = '0;
    best_val = x_r[0];
    for (int i = 0; i < LANES; i++) begin
      nz_count = nz_count + 3'(x_r[i] != FP32_ZERO);
    end
    for (int i = 1; i < LANES; i++) begin
      if (x_r[i] > best_val) begin
        best_val = x_r[i];
        best_idx = 2'(i);
      end
    end
  end

  assign in_ready  = (state == IDLE) && rdy_en;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_x      = 1'b0;
    iter_clr    = 1'b0;
    iter_inc    = 1'b0;
    latch_res   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load_x    = 1'b1;
          iter_clr  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (nz_count <= 3'd1) begin
          latch_res = 1'b1;
          state_nxt = DONE;
        end else if (iter == ITER_MAX) begin
          latch_res   = 1'b1;
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          load_x   = 1'b1;
          iter_inc = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        x_r[i] <= FP32_ZERO;
      end
      iter        <= '0;
      rdy_en      <= 1'b0;
      out_winner  <= '0;
      out_value   <= FP32_ZERO;
      out_none    <= 1'b0;
      out_timeout <= 1'b0;
      out_iters   <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (load_x) begin
        for (int i = 0; i < LANES; i++) begin
          x_r[i] <= relu_out[i];
        end
      end
      if (iter_clr) begin
        iter <= '0;
      end else if (iter_inc) begin
        iter <= iter + ITER_W'(1);
      end
      if (latch_res) begin
        out_none    <= (nz_count == 3'd0);
        out_winner  <= (nz_count == 3'd0) ? 2'd0 : best_idx;
        out_value   <= (nz_count == 3'd0) ? FP32_ZERO : best_val;
        out_timeout <= timeout_nxt;
        out_iters   <= iter;
      end
    end
  end

endmodule
